// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and the LSU, one transaction in flight at a time.
// Latency: grant is combinational in the request cycle, response is passed straight through (best case 2 cycles/txn).
// Backpressure: requesters hold req/payload until gnt; MEM_ARB_ROUND_ROBIN_EN selects round-robin ties, else LSU wins.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  output logic                  if_err_o,
  input  logic                  lsu_req_i,
  input  logic                  lsu_we_i,
  input  logic [3:0]            lsu_be_i,
  input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  output logic                  lsu_gnt_o,
  output logic                  lsu_rvalid_o,
  output logic [DATA_WIDTH-1:0] lsu_rdata_o,
  output logic                  lsu_err_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_err_i
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_IF  = 2'd1,
    WAIT_LSU = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   any_req;
  logic   tie_lsu;
  logic   pick_lsu;

  assign any_req = if_req_i | lsu_req_i;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_lsu_q;
  logic granted;

  assign granted = (state_q == IDLE) && any_req && mem_gnt_i;

  // Last owner resets to fetch, so the first tie after reset goes to the LSU.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_lsu_q <= 1'b0;
    end else if (granted) begin
      last_lsu_q <= pick_lsu;
    end
  end

  assign tie_lsu = ~last_lsu_q;
`else
  assign tie_lsu = 1'b1;
`endif

  assign pick_lsu = lsu_req_i & (~if_req_i | tie_lsu);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_be_o     = 4'b0000;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    if_gnt_o     = 1'b0;
    if_rvalid_o  = 1'b0;
    if_err_o     = 1'b0;
    lsu_gnt_o    = 1'b0;
    lsu_rvalid_o = 1'b0;
    lsu_err_o    = 1'b0;
    case (state_q)
      IDLE: begin
        // Winner is re-evaluated every cycle until the memory grants it.
        if (any_req) begin
          mem_req_o = 1'b1;
          if (pick_lsu) begin
            mem_we_o    = lsu_we_i;
            mem_be_o    = lsu_be_i;
            mem_addr_o  = lsu_addr_i;
            mem_wdata_o = lsu_wdata_i;
            lsu_gnt_o   = mem_gnt_i;
            if (mem_gnt_i) begin
              state_d = WAIT_LSU;
            end
          end else begin
            mem_be_o   = 4'b1111;
            mem_addr_o = if_addr_i;
            if_gnt_o   = mem_gnt_i;
            if (mem_gnt_i) begin
              state_d = WAIT_IF;
            end
          end
        end
      end
      WAIT_IF: begin
        if (mem_rvalid_i) begin
          if_rvalid_o = 1'b1;
          if_err_o    = mem_err_i;
          state_d     = IDLE;
        end
      end
      WAIT_LSU: begin
        if (mem_rvalid_i) begin
          lsu_rvalid_o = 1'b1;
          lsu_err_o    = mem_err_i;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign if_rdata_o  = mem_rdata_i;
  assign lsu_rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic          if_gnt_o, if_rvalid_o, if_err_o;
  logic [DW-1:0] if_rdata_o;
  logic          lsu_req_i, lsu_we_i;
  logic [3:0]    lsu_be_i;
  logic [AW-1:0] lsu_addr_i;
  logic [DW-1:0] lsu_wdata_i;
  logic          lsu_gnt_o, lsu_rvalid_o, lsu_err_o;
  logic [DW-1:0] lsu_rdata_o;
  logic          mem_req_o, mem_we_o;
  logic [3:0]    mem_be_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_gnt_i, mem_rvalid_i, mem_err_i;
  logic [DW-1:0] mem_rdata_i;

  int checks = 0;
  int errors = 0;

  // Model: who owns the outstanding transaction (0 none, 1 fetch, 2 LSU) and who owned the last grant.
  int             own = 0;
  bit             last_lsu = 1'b0;
  int             win;
  logic [139:0]   exp;
  logic [139:0]   obs;

  assign obs = {mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
                if_gnt_o, if_rvalid_o, if_err_o, lsu_gnt_o, lsu_rvalid_o, lsu_err_o,
                (if_rvalid_o ? if_rdata_o : 32'h0), (lsu_rvalid_o ? lsu_rdata_o : 32'h0)};

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_be_i(lsu_be_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_gnt_o(lsu_gnt_o), .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
    .lsu_err_o(lsu_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .mem_err_i(mem_err_i)
  );

  task automatic idle_inputs();
    rst = 1'b0; if_req_i = 1'b0; if_addr_i = '0;
    lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_be_i = 4'h0; lsu_addr_i = '0; lsu_wdata_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = '0;
  endtask

  // Move to the falling edge and compute what the outputs must be this cycle.
  task automatic settle();
    logic          e_we, rv_if, rv_lsu;
    logic [3:0]    e_be;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    @(negedge clk);
    win = 0;
    if (own == 0) begin
      if (if_req_i && lsu_req_i) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        win = last_lsu ? 1 : 2;
`else
        win = 2;
`endif
      end else if (lsu_req_i) win = 2;
      else if (if_req_i) win = 1;
    end
    e_we    = (win == 2) ? lsu_we_i : 1'b0;
    e_be    = (win == 2) ? lsu_be_i : ((win == 1) ? 4'hF : 4'h0);
    e_addr  = (win == 2) ? lsu_addr_i : ((win == 1) ? if_addr_i : '0);
    e_wdata = (win == 2) ? lsu_wdata_i : '0;
    rv_if   = (own == 1) && mem_rvalid_i;
    rv_lsu  = (own == 2) && mem_rvalid_i;
    exp = {(win != 0), e_we, e_be, e_addr, e_wdata,
           (win == 1) && mem_gnt_i, rv_if, rv_if && mem_err_i,
           (win == 2) && mem_gnt_i, rv_lsu, rv_lsu && mem_err_i,
           (rv_if ? mem_rdata_i : 32'h0), (rv_lsu ? mem_rdata_i : 32'h0)};
  endtask

  // Apply the clock edge to the model and the DUT.
  task automatic advance();
    if (rst) begin
      own = 0; last_lsu = 1'b0;
    end else if (own == 0 && win != 0 && mem_gnt_i) begin
      own = win; last_lsu = (win == 2);
    end else if (own != 0 && mem_rvalid_i) begin
      own = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    own = 0; last_lsu = 1'b0;
    settle();
    checks++;
    if (obs !== 140'h0) begin errors++; $display("FAIL reset_hold: got %h expected 0", obs); end
    advance();
    rst = 1'b0;
    settle();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_release: got %h expected %h", obs, exp); end
    advance();
  endtask

  task automatic test_fetch_only();
    idle_inputs();
    if_req_i = 1'b1; if_addr_i = 32'h100; mem_gnt_i = 1'b1;
    settle();
    checks++;
    if ({if_gnt_o, lsu_gnt_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o} !== {3'b101, 1'b0, 4'hF, 32'h100})
      begin errors++; $display("FAIL fetch_grant: got %b %b %b %b %h %h expected 1 0 1 0 f 100",
                               if_gnt_o, lsu_gnt_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o); end
    advance();
    idle_inputs();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
    settle();
    checks++;
    if ({if_rvalid_o, if_rdata_o} !== {1'b1, 32'hDEADBEEF})
      begin errors++; $display("FAIL fetch_rvalid: got %b %h expected 1 deadbeef", if_rvalid_o, if_rdata_o); end
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL fetch_rvalid_all: got %h expected %h", obs, exp); end
    advance();
    idle_inputs();
  endtask

  task automatic test_store_tie();
    idle_inputs();
    if_req_i = 1'b1; if_addr_i = 32'h300;
    lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_be_i = 4'b0011; lsu_addr_i = 32'h2000; lsu_wdata_i = 32'h1234;
    mem_gnt_i = 1'b1;
    settle();
    checks++;
    if ({mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, lsu_gnt_o, if_gnt_o} !== {1'b1, 4'b0011, 32'h2000, 32'h1234, 2'b10})
      begin errors++; $display("FAIL store_tie: got %b %b %h %h %b %b expected 1 0011 2000 1234 1 0",
                               mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, lsu_gnt_o, if_gnt_o); end
    advance();
    lsu_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5A5A0001;
    settle();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL store_resp: got %h expected %h", obs, exp); end
    advance();
    idle_inputs();
  endtask

  task automatic test_tie_order();
    logic [1:0] order [4];
`ifdef MEM_ARB_ROUND_ROBIN_EN
    order = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    order = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    idle_inputs();
    rst = 1'b1;
    settle();
    advance();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if_req_i = 1'b1; if_addr_i = 32'h1000 + 32'(k * 4);
      lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_be_i = 4'hF; lsu_addr_i = 32'h8000 + 32'(k * 4);
      mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0;
      settle();
      checks++;
      if ({if_gnt_o, lsu_gnt_o} !== order[k])
        begin errors++; $display("FAIL tie_order_%0d: got if/lsu gnt %b expected %b", k, {if_gnt_o, lsu_gnt_o}, order[k]); end
      advance();
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = $urandom;
      settle();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL tie_resp_%0d: got %h expected %h", k, obs, exp); end
      advance();
    end
    idle_inputs();
  endtask

  task automatic test_load_err();
    idle_inputs();
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_be_i = 4'hF; lsu_addr_i = 32'h4444; mem_gnt_i = 1'b1;
    settle();
    advance();
    idle_inputs();
    mem_rvalid_i = 1'b1; mem_err_i = 1'b1; mem_rdata_i = 32'hBAD0BAD0;
    settle();
    checks++;
    if ({lsu_rvalid_o, lsu_err_o, if_rvalid_o, if_err_o} !== 4'b1100)
      begin errors++; $display("FAIL load_err: got %b expected 1100", {lsu_rvalid_o, lsu_err_o, if_rvalid_o, if_err_o}); end
    advance();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    lsu_req_i = 1'b1; lsu_addr_i = 32'h7000; lsu_be_i = 4'hF; mem_gnt_i = 1'b1;
    settle();
    advance();
    idle_inputs();
    rst = 1'b1;
    settle();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_mid_wait: got %h expected %h", obs, exp); end
    advance();
    idle_inputs();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h11112222; if_req_i = 1'b1; if_addr_i = 32'h40;
    settle();
    checks++;
    if ({if_rvalid_o, lsu_rvalid_o, mem_req_o, mem_addr_o} !== {3'b001, 32'h40})
      begin errors++; $display("FAIL reset_drop: got rv %b%b req %b addr %h expected 00 1 40",
                               if_rvalid_o, lsu_rvalid_o, mem_req_o, mem_addr_o); end
    advance();
    idle_inputs();
  endtask

  task automatic test_displace();
    idle_inputs();
    if_req_i = 1'b1; if_addr_i = 32'h100;
    for (int c = 0; c < 2; c++) begin
      settle();
      checks++;
      if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h100})
        begin errors++; $display("FAIL displace_if_%0d: got %b %h expected 1 100", c, mem_req_o, mem_addr_o); end
      advance();
    end
    lsu_req_i = 1'b1; lsu_addr_i = 32'h2000; lsu_be_i = 4'hF;
    settle();
    checks++;
    if (mem_addr_o !== 32'h2000) begin errors++; $display("FAIL displace_lsu: got %h expected 2000", mem_addr_o); end
    advance();
    mem_gnt_i = 1'b1;
    settle();
    checks++;
    if ({if_gnt_o, lsu_gnt_o} !== 2'b01) begin errors++; $display("FAIL displace_gnt: got %b expected 01", {if_gnt_o, lsu_gnt_o}); end
    advance();
    lsu_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE0000;
    settle();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL displace_resp: got %h expected %h", obs, exp); end
    advance();
    idle_inputs();
  endtask

  task automatic test_random();
    bit ip = 1'b0;
    bit lp = 1'b0;
    idle_inputs();
    for (int c = 0; c < 3000; c++) begin
      if (!ip && $urandom_range(0, 9) < 4) begin ip = 1'b1; if_addr_i = $urandom; end
      if (!lp && $urandom_range(0, 9) < 4) begin
        lp = 1'b1; lsu_we_i = 1'($urandom_range(0, 1)); lsu_be_i = 4'($urandom);
        lsu_addr_i = $urandom; lsu_wdata_i = $urandom;
      end
      if_req_i     = ip;
      lsu_req_i    = lp;
      mem_gnt_i    = ($urandom_range(0, 9) < 6);
      mem_rvalid_i = 1'($urandom_range(0, 1));
      mem_err_i    = ($urandom_range(0, 3) == 0);
      mem_rdata_i  = $urandom;
      rst          = ($urandom_range(0, 99) == 0);
      settle();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL random_%0d: got %h expected %h", c, obs, exp); end
      if (own == 0 && mem_gnt_i && win == 1) ip = 1'b0;
      if (own == 0 && mem_gnt_i && win == 2) lp = 1'b0;
      advance();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_store_tie();
    test_tie_order();
    test_load_err();
    test_reset_mid();
    test_displace();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
